// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared constants, types and helpers for the word-serial AES datapath stages.
//   NB      : columns per AES state (and bytes per column)
//   BYTE_W  : width of one state byte
//   col_t   : one state column, row 0 in the most significant byte
//   state_t : a whole state, NB columns
//   get_byte(col, row) : extracts byte 'row' of a column (row 0 = MSB)
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NB     = 4;
    localparam int BYTE_W = 8;
    localparam int REG_W  = NB * BYTE_W;

    typedef logic [REG_W-1:0] col_t;
    typedef col_t state_t [NB];

    // Row 0 sits in the top byte, so higher rows need a smaller shift.
    function automatic logic [BYTE_W-1:0] get_byte(input col_t col, input int unsigned row);
        get_byte = BYTE_W'(col >> (BYTE_W * (NB - 1 - row)));
    endfunction

endpackage

// File: rtl/inv_shift_rows_stream_if.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stream_if
// Bundles the input and output column streams of inv_shift_rows_stream.
//   in_valid / in_ready / in_data              : column stream into the block
//   out_valid / out_ready / out_data / out_last : permuted column stream out
// Modports:
//   slave  : the inv_shift_rows_stream block itself
//   master : the environment feeding and draining the block
//
// Handshake (both streams): a beat transfers on a rising clock edge where
// valid && ready. Once valid is raised it stays high, with data/last stable,
// until that transfer happens. ready may depend on the receiver's registered
// state only, never combinationally on valid.
// -----------------------------------------------------------------------------
interface inv_shift_rows_stream_if #(
    parameter int regSize = 32
);

    logic               in_valid;
    logic               in_ready;
    logic [regSize-1:0] in_data;

    logic               out_valid;
    logic               out_ready;
    logic [regSize-1:0] out_data;
    logic               out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/inv_shift_rows.sv
// -----------------------------------------------------------------------------
// inv_shift_rows
// Combinational AES InvShiftRows on a whole state.
//   vect_in  : input state, vecSize columns of regSize bits
//   vect_out : permuted state; out column c, row r = in column (c - r) mod
//              vecSize, row r. Row r occupies bits regSize-1-8r : regSize-8-8r.
// -----------------------------------------------------------------------------
module inv_shift_rows
    import aes_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4
) (
    input  logic [regSize-1:0] vect_in  [vecSize],
    output logic [regSize-1:0] vect_out [vecSize]
);

    localparam int ROWS = regSize / BYTE_W;

    // Pure wiring: every byte lane is routed from a fixed source column.
    for (genvar c = 0; c < vecSize; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int HI  = regSize - 1 - BYTE_W * r;
            localparam int SRC = (c - r + vecSize) % vecSize;
            assign vect_out[c][HI -: BYTE_W] = vect_in[SRC][HI -: BYTE_W];
        end
    end

endmodule

// File: rtl/inv_shift_rows_stream.sv
// -----------------------------------------------------------------------------
// inv_shift_rows_stream
// Word-serial InvShiftRows stage. Collects a state one column per beat into
// one half of a ping-pong buffer, then streams the permuted state out one
// column per beat from the other half, sustaining one column per cycle.
//   clk  : clock
//   rst  : asynchronous active-high reset, discards all buffered data
//   clr  : synchronous soft clear, same effect as rst, wins over handshakes
//   bus  : stream interface (slave modport)
//          in_valid/in_ready/in_data   : input columns, row 0 in the MSB
//          out_valid/out_ready/out_data: permuted output columns (0 when idle)
//          out_last                    : final column of a state
// -----------------------------------------------------------------------------
module inv_shift_rows_stream
    import aes_pkg::*;
#(
    parameter int regSize = 32,
    parameter int vecSize = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    inv_shift_rows_stream_if.slave bus
);

    localparam int              CW       = (vecSize > 1) ? $clog2(vecSize) : 1;
    localparam logic [CW-1:0]   LAST_COL = CW'(vecSize - 1);

    // The permutation only makes sense on a square byte matrix.
    if (regSize / BYTE_W != vecSize) begin : g_size_check
        $error("inv_shift_rows_stream: regSize/8 must equal vecSize");
    end

    logic [regSize-1:0] mem_q [2][vecSize];
    logic [1:0]         full_q;
    logic               wsel_q;
    logic               rsel_q;
    logic [CW-1:0]      wcol_q;
    logic [CW-1:0]      rcol_q;

    logic               in_fire;
    logic               out_fire;
    logic [regSize-1:0] rd_state   [vecSize];
    logic [regSize-1:0] perm_state [vecSize];

    // Ready looks only at registered flags, so a buffer freed on one edge
    // becomes writable from the following cycle.
    assign bus.in_ready  = !full_q[wsel_q];
    assign bus.out_valid = full_q[rsel_q];

    assign in_fire  = bus.in_valid && bus.in_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    // Column storage carries no reset; the full flags decide what is valid.
    always_ff @(posedge clk) begin
        if (in_fire && !clr) begin
            mem_q[wsel_q][wcol_q] <= bus.in_data;
        end
    end

    // Write and read side only ever touch different halves (wsel != rsel
    // whenever both fire), so both updates can land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcol_q <= '0;
            rcol_q <= '0;
        end else if (clr) begin
            full_q <= 2'b00;
            wsel_q <= 1'b0;
            rsel_q <= 1'b0;
            wcol_q <= '0;
            rcol_q <= '0;
        end else begin
            if (in_fire) begin
                if (wcol_q == LAST_COL) begin
                    wcol_q         <= '0;
                    full_q[wsel_q] <= 1'b1;
                    wsel_q         <= ~wsel_q;
                end else begin
                    wcol_q <= wcol_q + 1'b1;
                end
            end
            if (out_fire) begin
                if (rcol_q == LAST_COL) begin
                    rcol_q         <= '0;
                    full_q[rsel_q] <= 1'b0;
                    rsel_q         <= ~rsel_q;
                end else begin
                    rcol_q <= rcol_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < vecSize; i++) begin
            rd_state[i] = mem_q[rsel_q][i];
        end
    end

    inv_shift_rows #(
        .regSize (regSize),
        .vecSize (vecSize)
    ) u_inv_shift_rows (
        .vect_in  (rd_state),
        .vect_out (perm_state)
    );

    // Output is a pure function of registered state, so it holds under stall.
    assign bus.out_data = bus.out_valid ? perm_state[rcol_q] : '0;
    assign bus.out_last = bus.out_valid && (rcol_q == LAST_COL);

endmodule

// File: tb/tb_inv_shift_rows_stream.sv
// -----------------------------------------------------------------------------
// tb_inv_shift_rows_stream
// Self-checking bench for inv_shift_rows_stream: directed blocks, back-to-back
// traffic, backpressure, random out_ready, soft clear and async reset.
// Expected columns come from a byte-matrix reference model and are queued on
// input acceptance; a negedge monitor pops and compares on each output beat.
// -----------------------------------------------------------------------------
module tb_inv_shift_rows_stream;
    import aes_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic clr;

    always #5 clk = ~clk;

    inv_shift_rows_stream_if #(.regSize(W)) bus ();

    inv_shift_rows_stream #(
        .regSize (W),
        .vecSize (N)
    ) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int         checks = 0;
    int         errors = 0;
    logic [W:0] exp_q[$];      // {last, data}
    state_t     blk_cols;
    int         blk_n;
    bit         rand_ready;
    int         mon_fires = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: build the byte matrix, rotate row r right by r places,
    // and read the result back column by column.
    function automatic void push_block(input state_t blk);
        logic [7:0] m       [N][N];
        logic [7:0] row_tmp [N];
        col_t       w;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = get_byte(blk[c], r);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) row_tmp[(c + r) % N] = m[r][c];
            for (int c = 0; c < N; c++) m[r][c] = row_tmp[c];
        end
        for (int c = 0; c < N; c++) begin
            w = '0;
            for (int r = 0; r < N; r++) w = {w[W-9:0], m[r][c]};
            exp_q.push_back({(c == N - 1), w});
        end
    endfunction

    function automatic void note_accept(input col_t d);
        blk_cols[blk_n] = d;
        blk_n++;
        if (blk_n == N) begin
            push_block(blk_cols);
            blk_n = 0;
        end
    endfunction

    // ---------------- driver tasks ----------------
    // All driving happens 2 time units after the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
        if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_col(input col_t d, output int stalls);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready && g < 200) begin
            step();
            g++;
        end
        stalls = g;
        if (!bus.in_ready) begin
            chk("in_ready timeout", W'(bus.in_ready), 1);
        end else begin
            step();
            note_accept(d);
        end
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            step();
            g++;
        end
        chk("drain queue empty", W'(exp_q.size()), 0);
    endtask

    // ---------------- monitor ----------------
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    logic [W:0]   e;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold out_valid", W'(bus.out_valid), 1);
                chk("hold out_data", bus.out_data, prev_data);
                chk("hold out_last", W'(bus.out_last), W'(prev_last));
            end
            if (!bus.out_valid) begin
                chk("idle out_data zero", bus.out_data, 0);
                chk("idle out_last zero", W'(bus.out_last), 0);
            end
            if (!clr && bus.out_valid && bus.out_ready) begin
                mon_fires++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h, expected no output", bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", bus.out_data, e[W-1:0]);
                    chk("out_last", W'(bus.out_last), W'(e[W]));
                end
            end
            prev_stall = !clr && bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
    end

    // ---------------- stimulus ----------------
    col_t basic_blk [N] = '{32'h7b746f5d, 32'h73744765, 32'h63535465, 32'h5d5b5672};
    col_t second_blk[N] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

    initial begin
        int   st;
        int   stall_sum;
        int   fires0;
        col_t d9;

        rst          = 1'b1;
        clr          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.out_ready = 1'b1;
        rand_ready   = 1'b0;
        blk_n        = 0;

        #7;
        chk("reset out_valid", W'(bus.out_valid), 0);
        chk("reset out_last", W'(bus.out_last), 0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset in_ready", W'(bus.in_ready), 1);

        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        step();

        // Basic block with out_ready held high.
        for (int i = 0; i < N - 1; i++) drive_col(basic_blk[i], st);
        chk("basic out_valid before last accept", W'(bus.out_valid), 0);
        drive_col(basic_blk[N-1], st);
        idle();
        chk("basic latency out_valid", W'(bus.out_valid), 1);
        chk("basic first column", bus.out_data, 32'h7b5b5465);
        chk("basic first not last", W'(bus.out_last), 0);
        wait_drain();

        // Two blocks back to back.
        stall_sum = 0;
        fires0    = mon_fires;
        for (int i = 0; i < N; i++) begin
            drive_col(basic_blk[i], st);
            stall_sum += st;
        end
        for (int i = 0; i < N; i++) begin
            drive_col(second_blk[i], st);
            stall_sum += st;
        end
        chk("b2b in_ready stalls", W'(stall_sum), 0);
        chk("b2b first state drained", W'(mon_fires - fires0), 4);
        chk("b2b no gap out_valid", W'(bus.out_valid), 1);
        chk("b2b second state col0", bus.out_data, 32'h00ddaa77);
        idle();
        wait_drain();

        // Backpressure: both buffers fill, then drain.
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) drive_col(basic_blk[i], st);
        for (int i = 0; i < N; i++) drive_col(second_blk[i], st);
        d9 = $urandom;
        bus.in_data = d9;
        chk("bp in_ready after 8th accept", W'(bus.in_ready), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp in_ready stalled", W'(bus.in_ready), 0);
            chk("bp out_valid held", W'(bus.out_valid), 1);
            chk("bp out_data held", bus.out_data, 32'h7b5b5465);
        end
        bus.out_ready = 1'b1;
        for (int k = 1; k <= N; k++) begin
            step();
            chk("bp in_ready release timing", W'(bus.in_ready), (k == N) ? 1 : 0);
        end
        step();
        note_accept(d9);
        for (int i = 1; i < N; i++) drive_col($urandom, st);
        idle();
        wait_drain();

        // Random out_ready over 20 blocks with random input gaps.
        fires0     = mon_fires;
        rand_ready = 1'b1;
        for (int b = 0; b < 20; b++) begin
            for (int c = 0; c < N; c++) begin
                drive_col($urandom, st);
                if ($urandom_range(0, 3) == 0) begin
                    idle();
                    step();
                end
            end
        end
        idle();
        rand_ready    = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        chk("random column count", W'(mon_fires - fires0), 80);

        // Soft clear with one full buffer and a partial block pending.
        bus.out_ready = 1'b0;
        for (int i = 0; i < N + 2; i++) drive_col($urandom, st);
        idle();
        chk("clr pre out_valid", W'(bus.out_valid), 1);
        clr = 1'b1;
        exp_q.delete();
        blk_n = 0;
        step();
        clr = 1'b0;
        chk("clr in_ready", W'(bus.in_ready), 1);
        chk("clr out_valid", W'(bus.out_valid), 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < N; i++) drive_col($urandom, st);
        idle();
        wait_drain();

        // Async reset while column 2 is on the output.
        bus.out_ready = 1'b0;
        for (int i = 0; i < N; i++) drive_col($urandom, st);
        idle();
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst pre out_valid", W'(bus.out_valid), 1);
        #1;
        rst = 1'b1;
        exp_q.delete();
        blk_n = 0;
        #1;
        chk("async rst out_valid", W'(bus.out_valid), 0);
        chk("async rst out_last", W'(bus.out_last), 0);
        chk("async rst out_data", bus.out_data, 0);
        chk("async rst in_ready", W'(bus.in_ready), 1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        step();
        for (int i = 0; i < N; i++) drive_col($urandom, st);
        idle();
        wait_drain();

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
